prog_loader: RTL
================

# prog_loader

Bitstream loader sitting directly upstream of the FPGA programming chain. It accepts a length-prefixed configuration stream as bytes over a valid/ready handshake, serializes it MSB-first onto the chain's `prog_clk`/`prog_en`/`prog_in` pins, and generates a divided programming clock from the system clock. It also counts the ones shifted back out on `prog_out`, which gives a cheap readback check of the previous configuration.

## Interface
Parameters:
- `CLK_DIV`, 2: system clocks per `prog_clk` phase. Must be ≥1.
- `LEN_WIDTH`, 16: width of the bit-length header and of `rb_ones`.

Ports:
- `clk`  in  1  system clock. All logic is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a load. Honoured only in IDLE.
- `abort`  in  1  synchronous abort. Returns to IDLE from any state.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  byte-stream data.
- `in_ready`  out  1  byte-stream ready. A transfer occurs when `in_valid && in_ready`.
- `prog_clk`  out  1  chain shift clock.
- `prog_en`  out  1  chain shift enable.
- `prog_in`  out  1  chain serial data.
- `prog_out`  in  1  chain serial readback.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a load completes.
- `rb_ones`  out  LEN_WIDTH  count of ones sampled from `prog_out` during the last load.

## Operation
- Stream format: length high byte, then length low byte (N = bit count, big-endian), then ceil(N/8) data bytes. Bits go out MSB-first. In the final byte only the top (N mod 8) bits are used when N mod 8 ≠ 0.
- States: IDLE, LEN_HI, LEN_LO, FETCH, SHIFT_LO, SHIFT_HI, DONE.
- IDLE:
  - `in_ready`=0.
  - `start` → LEN_HI. On the same transition `rb_ones` clears to 0.
- LEN_HI / LEN_LO:
  - `in_ready`=1. Each accepted byte loads the corresponding half of the length register and advances the state.
  - From LEN_LO: N=0 → DONE; otherwise → FETCH.
- FETCH:
  - `in_ready`=1, `prog_en`=1, `prog_clk`=0.
  - An accepted byte loads the shift register and the state goes to SHIFT_LO.
  - With no `in_valid`, the block stalls here indefinitely. `prog_clk` holds low, which is legal for the chain.
- SHIFT_LO:
  - Lasts CLK_DIV cycles. `prog_clk`=0, `prog_in`=current bit, `prog_en`=1.
  - On the last cycle `prog_out` is sampled and `rb_ones` increments if it is 1.
  - Then → SHIFT_HI.
- SHIFT_HI:
  - Lasts CLK_DIV cycles. `prog_clk`=1, `prog_in` is held.
  - On exit the remaining-bit counter decrements:
    - counter reaches 0 → DONE;
    - otherwise, bits remain in the current byte → SHIFT_LO with the next bit;
    - otherwise → FETCH.
- DONE: one cycle. `done`=1, `prog_en`=0, `prog_clk`=0. Then → IDLE.
- `abort`, in any state:
  - next cycle: IDLE, `prog_en`=0, `prog_clk`=0, no `done` pulse;
  - `rb_ones` keeps its partial value.
  - `abort` has priority over `start` and over a simultaneous handshake; the byte is not consumed (`in_ready` is forced to 0 that cycle).
- `start` outside IDLE is ignored.
- Arithmetic:
  - the bit counter is LEN_WIDTH bits, so N up to 2^LEN_WIDTH−1;
  - `rb_ones` ≤ N, so it never wraps.

## Timing
- All outputs are registered except `in_ready`, which is a decode of the state and `abort`.
- Reset values: state IDLE; `in_ready`, `prog_clk`, `prog_en`, `prog_in`, `busy`, `done` all 0; `rb_ones`=0.
- `start` at cycle t puts the block in LEN_HI at t+1, with `busy`=1 from t+1.
- The first `prog_clk` rising edge comes 1 + CLK_DIV cycles after the first data byte is accepted:
  - 1 cycle to enter SHIFT_LO;
  - CLK_DIV cycles in the low phase.
- `prog_in` is stable for CLK_DIV cycles before and CLK_DIV cycles after each `prog_clk` rise.
- With continuous `in_valid`:
  - each bit costs 2·CLK_DIV cycles;
  - each byte boundary adds 1 FETCH cycle.
- `done` pulses exactly 1 cycle after the final SHIFT_HI phase; IDLE follows 1 cycle later.
- Reset asserted mid-shift forces all outputs to their reset values immediately (asynchronous). Chain contents are then undefined and software must reload.

## Test plan
- CLK_DIV=2. Stream 0x00,0x08,0xA5 after `start` → `prog_in` sequence 1,0,1,0,0,1,0,1 on 8 `prog_clk` rises spaced 4 cycles apart; `done` pulses once; `busy` falls the cycle after `done`.
- N=0x000B with bytes 0xFF,0xE0 → exactly 11 `prog_clk` rises; the final 5 bits of the second byte are never driven out; the stream ends after 2 data bytes.
- Chain model returns alternating 1,0 on `prog_out` for an N=16 load → `rb_ones`=8 at `done`.
- N=0 → DONE directly; no `prog_clk` edge; `prog_en` never rises; `done` pulses 1 cycle after the length low byte is accepted.
- `in_valid` dropped for 10 cycles between data bytes → `prog_clk` holds low in FETCH, `prog_en` stays 1, and the output bit sequence is unchanged versus the no-stall run.
- `abort` on the 3rd `prog_clk` high phase, concurrently with `in_valid`=1 → next cycle IDLE with `prog_en`=0; no `done`; no byte consumed; `rb_ones` holds its partial count. A following `start` with a fresh stream completes normally.

Source files
------------

// File: rtl/prog_loader.sv
`timescale 1ns/1ps
// prog_loader: accepts a length-prefixed byte stream and shifts it MSB-first
// onto an FPGA programming chain with a divided shift clock, counting the
// ones returned on the chain's readback pin.
module prog_loader #(
   parameter int unsigned CLK_DIV   = 2,
   parameter int unsigned LEN_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 in_valid,
   input  logic [7:0]           in_data,
   output logic                 in_ready,
   output logic                 prog_clk,
   output logic                 prog_en,
   output logic                 prog_in,
   input  logic                 prog_out,
   output logic                 busy,
   output logic                 done,
   output logic [LEN_WIDTH-1:0] rb_ones
);

   // Phase counter must hold CLK_DIV-1; keep at least one bit for CLK_DIV=1.
   localparam int unsigned    DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_FETCH,
      S_SHIFT_LO,
      S_SHIFT_HI,
      S_DONE
   } state_t;

   state_t               r_state;
   state_t               w_next_state;

   logic [7:0]           r_len_hi;
   logic [LEN_WIDTH-1:0] r_bits_left;
   logic [7:0]           r_shift;
   logic [2:0]           r_bit_idx;
   logic [DIV_W-1:0]     r_div;
   logic [LEN_WIDTH-1:0] r_rb_ones;
   logic                 r_prog_clk;
   logic                 r_prog_en;
   logic                 r_busy;
   logic                 r_done;

   logic                 w_in_ready;
   logic                 w_accept;
   logic                 w_phase_end;
   logic [LEN_WIDTH-1:0] w_len;
   logic                 w_load_byte;
   logic                 w_next_bit;
   logic                 w_bit_done;
   logic                 w_sample;
   logic                 w_clear_rb;
   logic                 w_prog_clk_nxt;
   logic                 w_prog_en_nxt;
   logic                 w_busy_nxt;
   logic                 w_done_nxt;

   // Handshake and phase-timing decodes shared by the FSM and datapath.
   assign w_accept    = in_valid && w_in_ready;
   assign w_phase_end = (r_div == DIV_LAST);
   assign w_len       = LEN_WIDTH'({r_len_hi, in_data});

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state, stream ready, and next values of the registered chain outputs.
   always_comb begin
      w_next_state = r_state;
      w_in_ready   = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next_state = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            w_in_ready = 1'b1;
            if (in_valid) begin
               w_next_state = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            w_in_ready = 1'b1;
            if (in_valid) begin
               w_next_state = (w_len == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            w_in_ready = 1'b1;
            if (in_valid) begin
               w_next_state = S_SHIFT_LO;
            end
         end
         S_SHIFT_LO: begin
            if (w_phase_end) begin
               w_next_state = S_SHIFT_HI;
            end
         end
         S_SHIFT_HI: begin
            if (w_phase_end) begin
               if (r_bits_left == LEN_WIDTH'(1)) begin
                  w_next_state = S_DONE;
               end else if (r_bit_idx != 3'd0) begin
                  w_next_state = S_SHIFT_LO;
               end else begin
                  w_next_state = S_FETCH;
               end
            end
         end
         S_DONE: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase

      // Abort wins over start and over any handshake in the same cycle.
      if (abort) begin
         w_next_state = S_IDLE;
         w_in_ready   = 1'b0;
      end

      w_prog_clk_nxt = (w_next_state == S_SHIFT_HI);
      w_prog_en_nxt  = (w_next_state == S_FETCH) ||
                       (w_next_state == S_SHIFT_LO) ||
                       (w_next_state == S_SHIFT_HI);
      w_busy_nxt     = (w_next_state != S_IDLE);
      w_done_nxt     = (w_next_state == S_DONE);
   end

   // Datapath event decodes.
   assign w_load_byte = (r_state == S_FETCH) && w_accept;
   assign w_next_bit  = (r_state == S_SHIFT_HI) && (w_next_state == S_SHIFT_LO);
   assign w_bit_done  = (r_state == S_SHIFT_HI) && w_phase_end && !abort;
   assign w_sample    = (r_state == S_SHIFT_LO) && w_phase_end && !abort;
   assign w_clear_rb  = (r_state == S_IDLE) && start && !abort;

   // Phase counter restarts on every state change and runs inside shift phases.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div <= '0;
      end else if (w_next_state != r_state) begin
         r_div <= '0;
      end else if ((r_state == S_SHIFT_LO) || (r_state == S_SHIFT_HI)) begin
         r_div <= r_div + DIV_W'(1);
      end
   end

   // Length header capture and remaining-bit counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_len_hi    <= '0;
         r_bits_left <= '0;
      end else begin
         if ((r_state == S_LEN_HI) && w_accept) begin
            r_len_hi <= in_data;
         end
         if ((r_state == S_LEN_LO) && w_accept) begin
            r_bits_left <= w_len;
         end else if (w_bit_done) begin
            r_bits_left <= r_bits_left - LEN_WIDTH'(1);
         end
      end
   end

   // Shift register; bit 7 is the bit currently on the chain data pin.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift   <= '0;
         r_bit_idx <= '0;
      end else if (w_load_byte) begin
         r_shift   <= in_data;
         r_bit_idx <= 3'd7;
      end else if (w_next_bit) begin
         r_shift   <= {r_shift[6:0], 1'b0};
         r_bit_idx <= r_bit_idx - 3'd1;
      end
   end

   // Readback ones counter; cleared on a new load, kept across an abort.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rb_ones <= '0;
      end else if (w_clear_rb) begin
         r_rb_ones <= '0;
      end else if (w_sample && prog_out) begin
         r_rb_ones <= r_rb_ones + LEN_WIDTH'(1);
      end
   end

   // Registered chain and status outputs, decoded from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prog_clk <= 1'b0;
         r_prog_en  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_prog_clk <= w_prog_clk_nxt;
         r_prog_en  <= w_prog_en_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
      end
   end

   assign in_ready = w_in_ready;
   assign prog_clk = r_prog_clk;
   assign prog_en  = r_prog_en;
   assign prog_in  = r_shift[7];
   assign busy     = r_busy;
   assign done     = r_done;
   assign rb_ones  = r_rb_ones;

endmodule
